// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32x32 multiply / 32/32 divide unit for the EX stage.
// One multiplier bit (shift-add) or one quotient bit (restoring divide) is
// produced per cycle; a full operation spends 32 cycles in RUN, one in DONE.
//
// Handshake: start is sampled only while busy=0 (IDLE). A start seen with
// flush=0 at a rising edge is accepted at that edge; operands and op are
// captured there and ignored afterwards. done pulses for exactly one cycle,
// and hi/lo carry the new result from that cycle on until the next completion.
// flush abandons an operation without touching hi/lo; reset beats everything.
module muldiv_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] operand_a,
   input  logic [31:0] operand_b,
   input  logic        flush,
   output logic        busy,
   output logic        stall,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;

   // Latched operation context
   logic [1:0]  op_q;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic        sign_a;
   logic        sign_b;
   logic [4:0]  iter_cnt;

   // Working register: mult = {partial product high, remaining multiplier};
   // div = {partial remainder, dividend bits shifting into quotient bits}.
   logic [63:0] acc;

   logic [31:0] hi_q;
   logic [31:0] lo_q;

   // Input-side decode
   logic        in_signed;
   logic [31:0] a_in_mag;
   logic [31:0] b_in_mag;
   logic        accept;

   // Iteration datapath
   logic [32:0] mul_sum;
   logic [63:0] mul_next;
   logic [32:0] div_trial;
   logic [63:0] div_next;
   logic [63:0] step_next;
   logic        last_iter;

   // Final result shaping
   logic        op_signed;
   logic        op_is_div;
   logic [63:0] prod_signed;
   logic [31:0] quo_final;
   logic [31:0] rem_final;
   logic [31:0] a_orig;
   logic [31:0] res_hi;
   logic [31:0] res_lo;

   // Signed ops are MULT (00) and DIV (10); op[1] selects divide.
   assign in_signed = ~op[0];
   assign op_signed = ~op_q[0];
   assign op_is_div = op_q[1];

   // Operand magnitudes for signed ops; unsigned ops pass raw values.
   always_comb begin
      a_in_mag = operand_a;
      b_in_mag = operand_b;
      if (in_signed && operand_a[31]) a_in_mag = 32'd0 - operand_a;
      if (in_signed && operand_b[31]) b_in_mag = 32'd0 - operand_b;
   end

   assign accept    = (state == IDLE) && start && !flush;
   assign last_iter = (state == RUN) && (iter_cnt == 5'd31);

   // Next-state logic; flush returns to IDLE from RUN or DONE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start && !flush) state_next = RUN;
         end
         RUN: begin
            if (flush)                    state_next = IDLE;
            else if (iter_cnt == 5'd31)   state_next = DONE;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // One iteration of shift-add multiply and of restoring divide.
   always_comb begin
      // Multiply: add multiplicand into the high half when the current
      // multiplier LSB is set, then shift the whole 65-bit sum right.
      mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_mag} : 33'd0);
      mul_next = {mul_sum, acc[31:1]};

      // Divide: shift {rem, dividend} left by one and try subtracting the
      // divisor from the top 33 bits; keep it only if it did not go negative.
      div_trial = acc[63:31] - {1'b0, b_mag};
      if (div_trial[32]) div_next = {acc[62:0], 1'b0};
      else               div_next = {div_trial[31:0], acc[30:0], 1'b1};

      step_next = op_is_div ? div_next : mul_next;
   end

   // Sign correction and the divide-by-zero override, applied to the value
   // the final iteration produces so it can be written on the DONE edge.
   always_comb begin
      prod_signed = step_next;
      if (op_signed && (sign_a ^ sign_b)) prod_signed = 64'd0 - step_next;

      quo_final = step_next[31:0];
      rem_final = step_next[63:32];
      if (op_signed && (sign_a ^ sign_b)) quo_final = 32'd0 - step_next[31:0];
      if (op_signed && sign_a)            rem_final = 32'd0 - step_next[63:32];

      // Rebuild the dividend exactly as presented (0x80000000 maps to itself).
      a_orig = a_mag;
      if (op_signed && sign_a) a_orig = 32'd0 - a_mag;

      res_hi = prod_signed[63:32];
      res_lo = prod_signed[31:0];
      if (op_is_div) begin
         if (b_mag == 32'd0) begin
            res_hi = a_orig;
            res_lo = 32'hFFFF_FFFF;
         end else begin
            res_hi = rem_final;
            res_lo = quo_final;
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Operand capture, iteration progress and result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q     <= 2'd0;
         a_mag    <= 32'd0;
         b_mag    <= 32'd0;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         iter_cnt <= 5'd0;
         acc      <= 64'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
      end else if (accept) begin
         op_q     <= op;
         a_mag    <= a_in_mag;
         b_mag    <= b_in_mag;
         sign_a   <= operand_a[31];
         sign_b   <= operand_b[31];
         iter_cnt <= 5'd0;
         // Multiply walks the multiplier; divide walks the dividend.
         acc      <= op[1] ? {32'd0, a_in_mag} : {32'd0, b_in_mag};
      end else if ((state == RUN) && !flush) begin
         acc      <= step_next;
         iter_cnt <= iter_cnt + 5'd1;
         if (last_iter) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
         end
      end
   end

   assign busy  = (state != IDLE);
   assign stall = (state == RUN);
   assign done  = (state == DONE);
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an
// arithmetic reference model (64-bit integer multiply / divide).
module tb_muldiv_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        flush;
   logic        busy;
   logic        stall;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks;
   int failures;

   logic [31:0] exp_hi;
   logic [31:0] exp_lo;

   muldiv_unit dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .flush     (flush),
      .busy      (busy),
      .stall     (stall),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: {hi, lo} computed with plain 64-bit arithmetic.
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint      sa;
      longint      sb;
      longint      q;
      longint      r;
      logic [63:0] p;
      logic [63:0] qv;
      logic [63:0] rv;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         2'b00: begin
            q = sa * sb;
            p = q;
         end
         2'b01: p = {32'd0, a} * {32'd0, b};
         2'b10: begin
            if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               qv = q;
               rv = r;
               p = {rv[31:0], qv[31:0]};
            end
         end
         default: begin
            if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
            else p = {a % b, a / b};
         end
      endcase
      return p;
   endfunction

   // Issue one operation, check latency/stall/hold/result. When noisy is set,
   // op, operands and start are scrambled while the unit is busy.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit noisy);
      logic [63:0] m;
      int          cycles;
      int          stall_cnt;
      m = model(o, a, b);
      @(negedge clk);
      start = 1'b1; op = o; operand_a = a; operand_b = b;
      tick();                                  // edge E0
      start = 1'b0;
      op = 2'($urandom_range(0, 3)); operand_a = $urandom; operand_b = $urandom;
      check({tag, "_e0_stall"}, {63'd0, stall}, 64'd1);
      check({tag, "_e0_hold"}, {hi, lo}, {exp_hi, exp_lo});
      cycles = 0;
      stall_cnt = 0;
      while (!done && cycles < 40) begin
         if (noisy) begin
            start = 1'($urandom_range(0, 1));
            op = 2'($urandom_range(0, 3)); operand_a = $urandom; operand_b = $urandom;
         end
         tick();
         cycles++;
         if (!done && stall) stall_cnt++;
         if (cycles == 16) check({tag, "_mid_hold"}, {hi, lo}, {exp_hi, exp_lo});
      end
      start = 1'b0;
      check({tag, "_latency"}, 64'(cycles), 64'd32);
      check({tag, "_stall_cycles"}, 64'(stall_cnt), 64'd31);
      check({tag, "_done_flags"}, {61'd0, done, stall, busy}, {61'd0, 3'b101});
      exp_hi = m[63:32];
      exp_lo = m[31:0];
      check({tag, "_result"}, {hi, lo}, m);
      tick();                                  // back to IDLE
      check({tag, "_idle"}, {61'd0, done, stall, busy}, 64'd0);
   endtask

   initial begin
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      int          done_seen;

      checks = 0;
      failures = 0;
      exp_hi = 32'd0;
      exp_lo = 32'd0;
      reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'd0;
      operand_a = 32'd0; operand_b = 32'd0;

      // Reset
      tick();
      tick();
      check("reset_flags", {61'd0, done, stall, busy}, 64'd0);
      check("reset_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // Directed arithmetic cases
      run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      check("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      run_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
      check("mult_neg3x7_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      run_op("mult_min_sq", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
      check("mult_min_sq_const", {hi, lo}, 64'h4000_0000_0000_0000);
      run_op("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
      check("div_neg7_2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
      run_op("divu_by0", 2'b11, 32'h0000_0064, 32'h0000_0000, 1'b0);
      check("divu_by0_const", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
      run_op("div_by0_neg", 2'b10, 32'hFFFF_FF00, 32'h0000_0000, 1'b0);

      // Flush and start rules
      run_op("multu_3x5", 2'b01, 32'd3, 32'd5, 1'b0);
      @(negedge clk);
      start = 1'b1; op = 2'b11; operand_a = 32'd100; operand_b = 32'd7;
      tick();                                  // E0
      start = 1'b0;
      repeat (4) tick();                       // now just after E4
      start = 1'b1; op = 2'b00; operand_a = 32'h1234_5678; operand_b = 32'hFFFF_0001;
      tick();                                  // E5: ignored
      start = 1'b0;
      check("busy_start_ignored", {62'd0, stall, busy}, 64'd3);
      repeat (4) tick();                       // just after E9
      flush = 1'b1;
      tick();                                  // E10
      flush = 1'b0;
      check("flush_flags", {61'd0, done, stall, busy}, 64'd0);
      check("flush_hilo", {hi, lo}, 64'h0000_0000_0000_000F);
      start = 1'b1; op = 2'b11; operand_a = 32'd100; operand_b = 32'd7;
      tick();                                  // E11
      start = 1'b0;
      check("restart_accepted", {62'd0, stall, busy}, 64'd3);
      done_seen = 0;
      for (int i = 0; i < 40 && done_seen == 0; i++) begin
         tick();
         if (done) done_seen = i + 1;
      end
      check("restart_latency", 64'(done_seen), 64'd32);
      check("restart_result", {hi, lo}, 64'h0000_0002_0000_000E);
      exp_hi = 32'd2; exp_lo = 32'd14;
      tick();

      // Flush and start together in IDLE: flush wins
      @(negedge clk);
      start = 1'b1; flush = 1'b1; op = 2'b01; operand_a = 32'd9; operand_b = 32'd9;
      tick();
      start = 1'b0; flush = 1'b0;
      check("flush_beats_start", {61'd0, done, stall, busy}, 64'd0);
      check("flush_beats_start_hilo", {hi, lo}, {exp_hi, exp_lo});

      // Randomized operations, some with busy-time noise on the inputs
      for (int n = 0; n < 24; n++) begin
         ro = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: rb = 32'hFFFF_FFFF;
            2: rb = 32'h8000_0000;
            3: rb = 32'($urandom_range(1, 20));
            default: rb = $urandom;
         endcase
         ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
         run_op("rand", ro, ra, rb, n[0]);
      end

      // Reset in the middle of a MULT
      @(negedge clk);
      start = 1'b1; op = 2'b00; operand_a = 32'h0001_0003; operand_b = 32'hFFFF_0005;
      tick();                                  // E0
      start = 1'b0;
      repeat (19) tick();                      // just after E19
      reset = 1'b1;
      tick();                                  // E20
      reset = 1'b0;
      check("midrun_reset_flags", {61'd0, done, stall, busy}, 64'd0);
      check("midrun_reset_hilo", {hi, lo}, 64'd0);
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done) done_seen++;
      end
      check("midrun_reset_no_done", 64'(done_seen), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
